// File: rtl/dcache_ctrl.sv
// Control FSM for a 2-way, write-back, write-allocate data cache.
// Hits complete combinationally in IDLE. A miss optionally writes back the
// dirty victim, then fills the line, and returns to IDLE so that the held
// request hits. The hit/miss handshake is Mealy, so outputs are decoded
// from state plus inputs and forced low while reset is asserted.
module dcache_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [1:0]       hit,
    input  logic [1:0]       dirty,
    input  logic             lru,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [1:0]       load_tag,
    output logic [1:0]       load_valid,
    output logic [1:0]       load_dirty,
    output logic             dirty_in,
    output logic [1:0]       load_data,
    output logic             data_sel,
    output logic             addr_sel,
    output logic             load_lru,
    output logic             lru_in,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } state_t;

    state_t           r_state;
    logic             r_evict_way;
    logic [CNT_W-1:0] r_hit_count;
    logic [CNT_W-1:0] r_miss_count;

    logic       w_req;
    logic       w_any_hit;
    logic       w_hit_way;
    logic [1:0] w_hit_mask;
    logic [1:0] w_evict_mask;

    // Way 0 wins when both ways report a hit.
    assign w_req        = mem_read | mem_write;
    assign w_any_hit    = |hit;
    assign w_hit_way    = ~hit[0];
    assign w_hit_mask   = w_hit_way ? 2'b10 : 2'b01;
    assign w_evict_mask = r_evict_way ? 2'b10 : 2'b01;

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // State, victim way and performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_evict_way  <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && w_any_hit) begin
                        r_hit_count <= r_hit_count + CNT_W'(1);
                    end else if (w_req) begin
                        r_evict_way  <= lru;
                        r_miss_count <= r_miss_count + CNT_W'(1);
                        r_state      <= dirty[lru] ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) r_state <= FILL;
                end
                FILL: begin
                    // The fill completes even if the CPU dropped its request.
                    if (pmem_resp) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Array strobes and memory handshakes decoded from state and inputs.
    always_comb begin
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        load_tag   = 2'b00;
        load_valid = 2'b00;
        load_dirty = 2'b00;
        dirty_in   = 1'b0;
        load_data  = 2'b00;
        data_sel   = 1'b0;
        addr_sel   = 1'b0;
        load_lru   = 1'b0;
        lru_in     = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_req && w_any_hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~w_hit_way;
                        // A simultaneous read and write is handled as a write.
                        if (mem_write) begin
                            load_data  = w_hit_mask;
                            data_sel   = 1'b0;
                            load_dirty = w_hit_mask;
                            dirty_in   = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    addr_sel   = 1'b1;
                end
                FILL: begin
                    pmem_read = 1'b1;
                    addr_sel  = 1'b0;
                    if (pmem_resp) begin
                        load_data  = w_evict_mask;
                        data_sel   = 1'b1;
                        load_tag   = w_evict_mask;
                        load_valid = w_evict_mask;
                        load_dirty = w_evict_mask;
                        dirty_in   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hits, clean and dirty misses, aborts,
// reset during writeback and counter wrap (CNT_W = 4).
module tb_dcache_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       hit;
    logic [1:0]       dirty;
    logic             lru;
    logic             pmem_resp;
    logic             mem_resp;
    logic             pmem_read;
    logic             pmem_write;
    logic [1:0]       load_tag;
    logic [1:0]       load_valid;
    logic [1:0]       load_dirty;
    logic             dirty_in;
    logic [1:0]       load_data;
    logic             data_sel;
    logic             addr_sel;
    logic             load_lru;
    logic             lru_in;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    logic [15:0] all_o;
    assign all_o = {mem_resp, pmem_read, pmem_write, load_tag, load_valid, load_dirty,
                    dirty_in, load_data, data_sel, addr_sel, load_lru, lru_in};

    int n_checks = 0;
    int n_fail   = 0;

    dcache_ctrl #(
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .hit        (hit),
        .dirty      (dirty),
        .lru        (lru),
        .pmem_resp  (pmem_resp),
        .mem_resp   (mem_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .load_tag   (load_tag),
        .load_valid (load_valid),
        .load_dirty (load_dirty),
        .dirty_in   (dirty_in),
        .load_data  (load_data),
        .data_sel   (data_sel),
        .addr_sel   (addr_sel),
        .load_lru   (load_lru),
        .lru_in     (lru_in),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00;
        dirty = 2'b00; lru = 1'b0; pmem_resp = 1'b0;

        // Reset: outputs gated even with a hitting request present.
        next();
        mem_read = 1'b1; hit = 2'b01;
        #1;
        chk("rst_outputs", 32'(all_o), 32'h0);
        chk("rst_hit_count", 32'(hit_count), 32'h0);
        chk("rst_miss_count", 32'(miss_count), 32'h0);
        next();
        rst = 1'b0; mem_read = 1'b0; hit = 2'b00;

        // Read hit in way 1.
        next();
        mem_read = 1'b1; hit = 2'b10;
        #1;
        chk("rd_hit_resp", 32'(mem_resp), 32'h1);
        chk("rd_hit_load_lru", 32'(load_lru), 32'h1);
        chk("rd_hit_lru_in", 32'(lru_in), 32'h0);
        chk("rd_hit_load_data", 32'(load_data), 32'h0);
        chk("rd_hit_load_dirty", 32'(load_dirty), 32'h0);
        next();
        mem_read = 1'b0; hit = 2'b00;
        #1;
        chk("rd_hit_count", 32'(hit_count), 32'h1);
        chk("idle_quiet", 32'(all_o), 32'h0);

        // Write hit in way 0.
        mem_write = 1'b1; hit = 2'b01;
        #1;
        chk("wr_hit_resp", 32'(mem_resp), 32'h1);
        chk("wr_hit_load_data", 32'(load_data), 32'h1);
        chk("wr_hit_load_dirty", 32'(load_dirty), 32'h1);
        chk("wr_hit_dirty_in", 32'(dirty_in), 32'h1);
        chk("wr_hit_data_sel", 32'(data_sel), 32'h0);
        chk("wr_hit_lru_in", 32'(lru_in), 32'h1);
        next();
        mem_write = 1'b0; hit = 2'b00;
        #1;
        chk("wr_hit_count", 32'(hit_count), 32'h2);

        // Clean read miss, victim way 1, response after 3 cycles.
        mem_read = 1'b1; lru = 1'b1; dirty = 2'b00;
        #1;
        chk("miss_no_resp", 32'(mem_resp), 32'h0);
        chk("miss_idle_no_pmem", 32'({pmem_read, pmem_write}), 32'h0);
        next();
        lru = 1'b0;
        #1;
        chk("fill_pmem_read", 32'(pmem_read), 32'h1);
        chk("fill_no_pmem_write", 32'(pmem_write), 32'h0);
        chk("fill_addr_sel", 32'(addr_sel), 32'h0);
        chk("clean_miss_count", 32'(miss_count), 32'h1);
        next();
        chk("fill_hold1", 32'({pmem_read, pmem_write}), 32'h2);
        next();
        chk("fill_hold2", 32'({pmem_read, pmem_write}), 32'h2);
        pmem_resp = 1'b1;
        #1;
        chk("fill_load_tag", 32'(load_tag), 32'h2);
        chk("fill_load_valid", 32'(load_valid), 32'h2);
        chk("fill_load_data", 32'(load_data), 32'h2);
        chk("fill_load_dirty", 32'(load_dirty), 32'h2);
        chk("fill_dirty_in", 32'(dirty_in), 32'h0);
        chk("fill_data_sel", 32'(data_sel), 32'h1);
        chk("fill_no_resp", 32'(mem_resp), 32'h0);
        next();
        pmem_resp = 1'b0; hit = 2'b10;
        #1;
        chk("clean_miss_resp", 32'(mem_resp), 32'h1);
        chk("clean_miss_pmem_idle", 32'({pmem_read, pmem_write}), 32'h0);
        next();
        mem_read = 1'b0; hit = 2'b00;
        #1;
        chk("clean_miss_hits", 32'(hit_count), 32'h3);
        chk("clean_miss_misses", 32'(miss_count), 32'h1);

        // Dirty write miss, victim way 0.
        mem_write = 1'b1; lru = 1'b0; dirty = 2'b01;
        next();
        dirty = 2'b00; lru = 1'b1;
        #1;
        chk("wb_pmem_write", 32'({pmem_read, pmem_write}), 32'h1);
        chk("wb_addr_sel", 32'(addr_sel), 32'h1);
        chk("dirty_miss_count", 32'(miss_count), 32'h2);
        next();
        chk("wb_hold", 32'({pmem_read, pmem_write, addr_sel}), 32'h3);
        pmem_resp = 1'b1;
        #1;
        chk("wb_resp_no_load", 32'(load_data), 32'h0);
        next();
        pmem_resp = 1'b0;
        #1;
        chk("wb_fill_pmem", 32'({pmem_read, pmem_write, addr_sel}), 32'h4);
        pmem_resp = 1'b1;
        #1;
        chk("wb_fill_load_tag", 32'(load_tag), 32'h1);
        chk("wb_fill_load_data", 32'(load_data), 32'h1);
        next();
        pmem_resp = 1'b0; hit = 2'b01;
        #1;
        chk("dirty_miss_resp", 32'(mem_resp), 32'h1);
        chk("dirty_miss_load_dirty", 32'(load_dirty), 32'h1);
        chk("dirty_miss_dirty_in", 32'(dirty_in), 32'h1);
        chk("dirty_miss_data_sel", 32'(data_sel), 32'h0);
        next();
        mem_write = 1'b0; hit = 2'b00;
        #1;
        chk("dirty_miss_hits", 32'(hit_count), 32'h4);

        // Request dropped during FILL.
        mem_read = 1'b1; lru = 1'b1; dirty = 2'b00;
        next();
        mem_read = 1'b0;
        #1;
        chk("abort_fill_pmem", 32'(pmem_read), 32'h1);
        pmem_resp = 1'b1;
        #1;
        chk("abort_fill_install", 32'(load_tag), 32'h2);
        chk("abort_fill_no_resp", 32'(mem_resp), 32'h0);
        next();
        pmem_resp = 1'b0;
        #1;
        chk("abort_idle", 32'(all_o), 32'h0);
        chk("abort_misses", 32'(miss_count), 32'h3);
        chk("abort_hits", 32'(hit_count), 32'h4);

        // Read and write together behave as a write.
        mem_read = 1'b1; mem_write = 1'b1; hit = 2'b10;
        #1;
        chk("rw_load_data", 32'(load_data), 32'h2);
        chk("rw_dirty_in", 32'(dirty_in), 32'h1);
        next();
        mem_read = 1'b0; mem_write = 1'b0; hit = 2'b00;
        #1;
        chk("rw_hits", 32'(hit_count), 32'h5);

        // Reset asserted during WRITEBACK.
        mem_read = 1'b1; lru = 1'b1; dirty = 2'b10;
        next();
        #1;
        chk("rst_wb_entry", 32'(pmem_write), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_wb_outputs", 32'(all_o), 32'h0);
        chk("rst_wb_hits", 32'(hit_count), 32'h0);
        chk("rst_wb_misses", 32'(miss_count), 32'h0);
        next();
        rst = 1'b0; mem_read = 1'b0; dirty = 2'b00;
        #1;
        chk("rst_wb_idle", 32'(all_o), 32'h0);
        next();
        chk("rst_wb_idle2", 32'(all_o), 32'h0);

        // Sixteen back-to-back read hits wrap a 4-bit counter.
        mem_read = 1'b1; hit = 2'b01;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("wrap_resp", 32'(mem_resp), 32'h1);
            if (i == 15) chk("wrap_pre", 32'(hit_count), 32'hf);
            next();
        end
        mem_read = 1'b0; hit = 2'b00;
        #1;
        chk("wrap_hit_count", 32'(hit_count), 32'h0);
        chk("wrap_miss_count", 32'(miss_count), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
